// File: rtl/seq_cmp_pkg.sv
// Shared types and sizing helpers for the sequential magnitude comparator.
package seq_cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_result_t;

  function automatic int numDigits(input int width, input int digit);
    return width / digit;
  endfunction

  // Index register never collapses to zero bits, even for a single digit step.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational compare of one DIGIT-bit slice; exactly one result flag is set.
module cmp_digit
  import seq_cmp_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output cmp_result_t      res
);

  always_comb begin
    res.gt = (a > b);
    res.lt = (a < b);
    res.eq = (a == b);
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, signed/unsigned.
// Define SEQ_CMP_EARLY_EXIT_EN to finish on the first differing slice instead of after N steps.
module seq_magnitude_comparator
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int N  = numDigits(WIDTH, DIGIT);
  localparam int IW = idxWidth(N);
  localparam logic [IW-1:0]    LAST_IDX = IW'(N - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : gBadCfg
    $error("seq_magnitude_comparator: WIDTH must be a multiple of DIGIT, 1 <= DIGIT <= WIDTH");
  end

  state_t           state, stateNxt;
  logic [WIDTH-1:0] aSh, bSh;
  logic [IW-1:0]    idx;
  cmp_result_t      sliceRes, finalRes;
  logic             finish;
`ifndef SEQ_CMP_EARLY_EXIT_EN
  cmp_result_t      stickyRes;
  logic             decided;
`endif

  cmp_digit #(.DIGIT(DIGIT)) uDigit (
    .a  (aSh[WIDTH-1 -: DIGIT]),
    .b  (bSh[WIDTH-1 -: DIGIT]),
    .res(sliceRes)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    finish   = 1'b0;
    finalRes = sliceRes;
    case (state)
      IDLE: if (start) stateNxt = RUN;
      RUN: begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
        finish = !sliceRes.eq || (idx == '0);
`else
        // First differing slice decides; later slices only matter if all were equal so far.
        finish = (idx == '0);
        if (decided) finalRes = stickyRes;
`endif
        if (finish) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aSh  <= '0;
      bSh  <= '0;
      idx  <= '0;
      done <= 1'b0;
      gt   <= 1'b0;
      lt   <= 1'b0;
      eq   <= 1'b0;
`ifndef SEQ_CMP_EARLY_EXIT_EN
      stickyRes <= '0;
      decided   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        // Offset binary: flipping both sign bits makes an unsigned compare order signed values.
        aSh <= signed_mode ? (a ^ MSB_MASK) : a;
        bSh <= signed_mode ? (b ^ MSB_MASK) : b;
        idx <= LAST_IDX;
`ifndef SEQ_CMP_EARLY_EXIT_EN
        decided <= 1'b0;
`endif
      end else if (state == RUN) begin
        aSh <= aSh << DIGIT;
        bSh <= bSh << DIGIT;
        idx <= idx - 1'b1;
`ifndef SEQ_CMP_EARLY_EXIT_EN
        if (!decided && !sliceRes.eq) begin
          decided   <= 1'b1;
          stickyRes <= sliceRes;
        end
`endif
        if (finish) begin
          done <= 1'b1;
          gt   <= finalRes.gt;
          lt   <= finalRes.lt;
          eq   <= finalRes.eq;
        end
      end
    end
  end

endmodule
